// File: rtl/uart_temp_report_pkg.sv
// uart_temp_report_pkg
// Shared constants and types for the periodic UART temperature reporter.
//   - ASCII codes used to build the report line
//   - sign-digit encoding for a negative reading
//   - state encodings for the byte serialiser and the line sequencer
//   - number of characters per report line
// Optional feature macro: TEMP_REPORT_UNIT_EN adds a trailing 'C' unit
// character after the tenths digit, making the line 8 characters long.
package uart_temp_report_pkg;

    localparam logic [7:0] ASCII_PLUS   = 8'h2B;
    localparam logic [7:0] ASCII_MINUS  = 8'h2D;
    localparam logic [7:0] ASCII_DOT    = 8'h2E;
    localparam logic [7:0] ASCII_CR     = 8'h0D;
    localparam logic [7:0] ASCII_LF     = 8'h0A;
    localparam logic [7:0] ASCII_QMARK  = 8'h3F;
    localparam logic [7:0] ASCII_UNIT_C = 8'h43;
    localparam logic [7:0] ASCII_ZERO   = 8'h30;

    localparam logic [3:0] SIGN_MINUS   = 4'hA;

    // Bit-level states of the byte serialiser.
    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    // Character-level states of the line sequencer.
    typedef enum logic [1:0] {
        RPT_IDLE = 2'd0,
        RPT_SEND = 2'd1,
        RPT_NEXT = 2'd2
    } rpt_state_t;

`ifdef TEMP_REPORT_UNIT_EN
    localparam int unsigned FRAME_CHARS = 8;
`else
    localparam int unsigned FRAME_CHARS = 7;
`endif

    // BCD digit to ASCII; non-decimal codes are flagged as '?'.
    function automatic logic [7:0] digit_ascii(input logic [3:0] digit);
        logic [7:0] code;
        if (digit <= 4'd9) begin
            code = ASCII_ZERO + {4'd0, digit};
        end else begin
            code = ASCII_QMARK;
        end
        return code;
    endfunction

endpackage

// File: rtl/uart_temp_report_tx_byte.sv
// uart_tx_byte
// 8N1 byte serialiser, LSB first, DIV clock cycles per bit.
// Ports:
//   clk, rst : clock and asynchronous active-high reset
//   start    : request to send data; accepted only while not busy
//   data     : byte to send, captured on the accepting edge
//   tx       : registered serial line, idle high
//   busy     : registered, high from the accepting edge to the end of stop
//   done     : high during the last cycle of the stop bit
module uart_tx_byte
    import uart_temp_report_pkg::*;
#(
    parameter int unsigned DIV = 10416
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int unsigned     CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    tx_state_t        state_r, state_s;
    logic [CNT_W-1:0] baud_cnt_r, baud_cnt_s;
    logic [2:0]       bit_cnt_r, bit_cnt_s;
    logic [7:0]       shift_r, shift_s;
    logic             tx_r, tx_s;
    logic             busy_r;
    logic             bit_end_s;

    // The baud counter counts down and reloads at each bit boundary, so every
    // bit lasts exactly DIV cycles with no accumulated drift.
    assign bit_end_s = (baud_cnt_r == {CNT_W{1'b0}});

    // Next-state logic: the tx value for the coming bit is computed here so
    // the line itself is a plain register.
    always_comb begin
        state_s    = state_r;
        baud_cnt_s = baud_cnt_r;
        bit_cnt_s  = bit_cnt_r;
        shift_s    = shift_r;
        tx_s       = tx_r;
        done       = 1'b0;
        case (state_r)
            TX_IDLE: begin
                if (start) begin
                    state_s    = TX_START;
                    tx_s       = 1'b0;
                    shift_s    = data;
                    bit_cnt_s  = 3'd0;
                    baud_cnt_s = CNT_LAST;
                end else begin
                    tx_s = 1'b1;
                end
            end
            TX_START: begin
                if (bit_end_s) begin
                    state_s    = TX_DATA;
                    tx_s       = shift_r[0];
                    baud_cnt_s = CNT_LAST;
                end else begin
                    baud_cnt_s = baud_cnt_r - CNT_W'(1);
                end
            end
            TX_DATA: begin
                if (bit_end_s) begin
                    baud_cnt_s = CNT_LAST;
                    if (bit_cnt_r == 3'd7) begin
                        state_s = TX_STOP;
                        tx_s    = 1'b1;
                    end else begin
                        bit_cnt_s = bit_cnt_r + 3'd1;
                        shift_s   = {1'b0, shift_r[7:1]};
                        tx_s      = shift_r[1];
                    end
                end else begin
                    baud_cnt_s = baud_cnt_r - CNT_W'(1);
                end
            end
            TX_STOP: begin
                if (bit_end_s) begin
                    state_s = TX_IDLE;
                    tx_s    = 1'b1;
                    done    = 1'b1;
                end else begin
                    baud_cnt_s = baud_cnt_r - CNT_W'(1);
                end
            end
            default: begin
                state_s = TX_IDLE;
                tx_s    = 1'b1;
            end
        endcase
    end

    // State, counters and the serial line register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= TX_IDLE;
            baud_cnt_r <= {CNT_W{1'b0}};
            bit_cnt_r  <= 3'd0;
            shift_r    <= 8'h00;
            tx_r       <= 1'b1;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            baud_cnt_r <= baud_cnt_s;
            bit_cnt_r  <= bit_cnt_s;
            shift_r    <= shift_s;
            tx_r       <= tx_s;
            busy_r     <= (state_s != TX_IDLE);
        end
    end

    assign tx   = tx_r;
    assign busy = busy_r;

endmodule

// File: rtl/uart_temp_report.sv
// uart_temp_report
// Once per report period, snapshots the four BCD display digits and sends
// an ASCII line such as "+23.5\r\n" over an 8N1 UART (LSB first).
// Optional feature macro: TEMP_REPORT_UNIT_EN inserts 'C' before CR.
// Ports:
//   clk, rst       : clock and asynchronous active-high reset
//   d3             : sign digit, 4'hA = minus, anything else = plus
//   d2, d1, d0     : tens, units, tenths BCD digits
//   tx_out         : registered UART line, idle high
//   busy           : registered, high while a report line is in progress
module uart_temp_report
    import uart_temp_report_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 100000000,
    parameter int unsigned BAUD      = 9600,
    parameter int unsigned PERIOD_MS = 1000
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] d3,
    input  logic [3:0] d2,
    input  logic [3:0] d1,
    input  logic [3:0] d0,
    output logic       tx_out,
    output logic       busy
);

    localparam int unsigned      DIV      = CLK_HZ / BAUD;
    localparam int unsigned      PERIOD   = PERIOD_MS * (CLK_HZ / 1000);
    localparam int unsigned      PER_W    = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(PERIOD - 1);
    localparam logic [2:0]       LAST_IDX = 3'(FRAME_CHARS - 1);

    logic [PER_W-1:0] period_cnt_r;
    logic             trigger_s;

    rpt_state_t  rpt_state_r, rpt_state_s;
    logic [2:0]  char_idx_r, char_idx_s;
    logic [2:0]  char_sel_s;
    logic [15:0] snap_r, snap_s;
    logic [15:0] src_s;
    logic        busy_r, busy_s;
    logic        start_s;
    logic [7:0]  byte_data_s;
    logic        byte_busy_s;
    logic        byte_done_s;

    // Free-running report period counter; the trigger is its terminal count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_cnt_r <= {PER_W{1'b0}};
        end else if (period_cnt_r == PER_LAST) begin
            period_cnt_r <= {PER_W{1'b0}};
        end else begin
            period_cnt_r <= period_cnt_r + PER_W'(1);
        end
    end

    assign trigger_s = (period_cnt_r == PER_LAST);

    // The first character is launched on the same edge that takes the
    // snapshot, so in IDLE the live digits feed the character mux.
    assign src_s = (rpt_state_r == RPT_IDLE) ? {d3, d2, d1, d0} : snap_r;

    // Line sequencer: launches each character and steps the char index.
    always_comb begin
        rpt_state_s = rpt_state_r;
        char_idx_s  = char_idx_r;
        char_sel_s  = char_idx_r;
        snap_s      = snap_r;
        busy_s      = busy_r;
        start_s     = 1'b0;
        case (rpt_state_r)
            RPT_IDLE: begin
                char_sel_s = 3'd0;
                if (trigger_s && !byte_busy_s) begin
                    rpt_state_s = RPT_SEND;
                    char_idx_s  = 3'd0;
                    snap_s      = {d3, d2, d1, d0};
                    busy_s      = 1'b1;
                    start_s     = 1'b1;
                end else begin
                    busy_s = 1'b0;
                end
            end
            RPT_SEND: begin
                if (byte_done_s) begin
                    rpt_state_s = RPT_NEXT;
                end else begin
                    rpt_state_s = RPT_SEND;
                end
            end
            RPT_NEXT: begin
                if (char_idx_r == LAST_IDX) begin
                    rpt_state_s = RPT_IDLE;
                    char_idx_s  = 3'd0;
                    busy_s      = 1'b0;
                end else begin
                    rpt_state_s = RPT_SEND;
                    char_idx_s  = char_idx_r + 3'd1;
                    char_sel_s  = char_idx_r + 3'd1;
                    start_s     = 1'b1;
                end
            end
            default: begin
                rpt_state_s = RPT_IDLE;
                char_idx_s  = 3'd0;
                busy_s      = 1'b0;
            end
        endcase
    end

    // Character mux: position in the line to ASCII code.
    always_comb begin
        byte_data_s = ASCII_LF;
        case (char_sel_s)
            3'd0: begin
                if (src_s[15:12] == SIGN_MINUS) begin
                    byte_data_s = ASCII_MINUS;
                end else begin
                    byte_data_s = ASCII_PLUS;
                end
            end
            3'd1: byte_data_s = digit_ascii(src_s[11:8]);
            3'd2: byte_data_s = digit_ascii(src_s[7:4]);
            3'd3: byte_data_s = ASCII_DOT;
            3'd4: byte_data_s = digit_ascii(src_s[3:0]);
`ifdef TEMP_REPORT_UNIT_EN
            3'd5: byte_data_s = ASCII_UNIT_C;
            3'd6: byte_data_s = ASCII_CR;
            3'd7: byte_data_s = ASCII_LF;
`else
            3'd5: byte_data_s = ASCII_CR;
            3'd6: byte_data_s = ASCII_LF;
`endif
            default: byte_data_s = ASCII_LF;
        endcase
    end

    // Sequencer state, snapshot and the busy output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rpt_state_r <= RPT_IDLE;
            char_idx_r  <= 3'd0;
            snap_r      <= 16'h0000;
            busy_r      <= 1'b0;
        end else begin
            rpt_state_r <= rpt_state_s;
            char_idx_r  <= char_idx_s;
            snap_r      <= snap_s;
            busy_r      <= busy_s;
        end
    end

    uart_tx_byte #(
        .DIV (DIV)
    ) u_tx_byte (
        .clk   (clk),
        .rst   (rst),
        .start (start_s),
        .data  (byte_data_s),
        .tx    (tx_out),
        .busy  (byte_busy_s),
        .done  (byte_done_s)
    );

    assign busy = busy_r;

endmodule

// File: tb/tb_uart_temp_report.sv
`timescale 1ns/1ps
module tb_uart_temp_report;

    localparam int CLK_HZ    = 1000;
    localparam int PERIOD_MS = 1000;
`ifdef TEMP_REPORT_UNIT_EN
    localparam int BAUD = 50;
    localparam int NCH  = 8;
`else
    localparam int BAUD = 100;
    localparam int NCH  = 7;
`endif
    localparam int DIV       = CLK_HZ / BAUD;
    localparam int PERIOD    = PERIOD_MS * (CLK_HZ / 1000);
    localparam int CHAR_CYC  = 10 * DIV + 1;
    localparam int FRAME_CYC = NCH * CHAR_CYC;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] d3 = 4'd0, d2 = 4'd0, d1 = 4'd0, d0 = 4'd0;
    logic       tx_out;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int next_start = 0;
    logic [7:0] exp_line [8];

    uart_temp_report #(
        .CLK_HZ    (CLK_HZ),
        .BAUD      (BAUD),
        .PERIOD_MS (PERIOD_MS)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .d3     (d3),
        .d2     (d2),
        .d1     (d1),
        .d0     (d0),
        .tx_out (tx_out),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    // cycles since reset release; equals the period counter value
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    function automatic logic [7:0] to_ascii(input logic [3:0] v);
        if (v < 4'd10) return 8'h30 + {4'h0, v};
        else           return 8'h3F;
    endfunction

    // expected report line for the given digits
    task automatic make_line(input logic [3:0] s, input logic [3:0] t,
                             input logic [3:0] u, input logic [3:0] f);
        int k;
        exp_line[0] = (s == 4'hA) ? 8'h2D : 8'h2B;
        exp_line[1] = to_ascii(t);
        exp_line[2] = to_ascii(u);
        exp_line[3] = 8'h2E;
        exp_line[4] = to_ascii(f);
        k = 5;
`ifdef TEMP_REPORT_UNIT_EN
        exp_line[5] = 8'h43;
        k = 6;
`endif
        exp_line[k]     = 8'h0D;
        exp_line[k + 1] = 8'h0A;
    endtask

    // a trigger is taken only once the previous line has finished
    function automatic int after(input int prev);
        int need;
        need = prev + FRAME_CYC + 1;
        return ((need + PERIOD - 1) / PERIOD) * PERIOD;
    endfunction

    // idle check up to start-1, then per-cycle waveform and decoded bytes
    task automatic check_frame(input int start, input string name,
                               input int chg_at, input logic [3:0] chg_val);
        int idle_n, idle_bad, bad, first_i, ch, off, pos;
        logic first_tx, first_busy, first_exp, exp_tx;
        logic [7:0] got [8];
        idle_n = 0; idle_bad = 0; bad = 0; first_i = -1;
        first_tx = 1'b0; first_busy = 1'b0; first_exp = 1'b0;
        for (int j = 0; j < 8; j++) got[j] = 8'h00;
        while (cyc < start - 1) begin
            @(negedge clk);
            idle_n++;
            if (tx_out !== 1'b1 || busy !== 1'b0) idle_bad++;
        end
        if (idle_n > 0) begin
            checks++;
            if (idle_bad !== 0) begin
                errors++;
                $display("FAIL %s idle: %0d non-idle cycles before cycle %0d, required 0", name, idle_bad, start);
            end
        end
        for (int i = 0; i < FRAME_CYC; i++) begin
            @(negedge clk);
            if (i == chg_at) d1 = chg_val;
            ch  = i / CHAR_CYC;
            off = i % CHAR_CYC;
            pos = off / DIV;
            if (off == 10 * DIV)  exp_tx = 1'b1;
            else if (pos == 0)    exp_tx = 1'b0;
            else if (pos == 9)    exp_tx = 1'b1;
            else                  exp_tx = exp_line[ch][pos - 1];
            if (tx_out !== exp_tx || busy !== 1'b1) begin
                if (first_i < 0) begin
                    first_i = i; first_tx = tx_out; first_busy = busy; first_exp = exp_tx;
                end
                bad++;
            end
            if (pos >= 1 && pos <= 8 && (off % DIV) == DIV / 2) got[ch][pos - 1] = tx_out;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL %s wave: %0d bad cycles, first at frame cycle %0d tx=%b busy=%b, required tx=%b busy=1",
                     name, bad, first_i, first_tx, first_busy, first_exp);
        end
        for (int c = 0; c < NCH; c++) begin
            checks++;
            if (got[c] !== exp_line[c]) begin
                errors++;
                $display("FAIL %s byte%0d: got %h, required %h", name, c, got[c], exp_line[c]);
            end
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || tx_out !== 1'b1) begin
            errors++;
            $display("FAIL %s end: busy=%b tx=%b, required busy=0 tx=1", name, busy, tx_out);
        end
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (tx_out !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset: tx=%b busy=%b, required tx=1 busy=0", tx_out, busy);
        end
        release_reset();
    endtask

    task automatic test_basic();
        d3 = 4'd0; d2 = 4'd2; d1 = 4'd3; d0 = 4'd5;
        make_line(d3, d2, d1, d0);
        next_start = PERIOD;
        check_frame(next_start, "basic", -1, 4'd0);
    endtask

    task automatic test_minus();
        d3 = 4'hA; d2 = 4'd0; d1 = 4'd7; d0 = 4'd0;
        make_line(d3, d2, d1, d0);
        next_start = after(next_start);
        check_frame(next_start, "minus", -1, 4'd0);
    endtask

    task automatic test_qmark();
        d3 = 4'd1; d2 = 4'hC; d1 = 4'd4; d0 = 4'd8;
        make_line(d3, d2, d1, d0);
        next_start = after(next_start);
        check_frame(next_start, "qmark", -1, 4'd0);
    endtask

    task automatic test_midframe();
        d3 = 4'd0; d2 = 4'd1; d1 = 4'd3; d0 = 4'd4;
        make_line(d3, d2, d1, d0);
        next_start = after(next_start);
        check_frame(next_start, "midframe", CHAR_CYC + 3 * DIV, 4'd9);
        make_line(4'd0, 4'd1, 4'd9, 4'd4);
        next_start = after(next_start);
        check_frame(next_start, "midframe_next", -1, 4'd0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 4; n++) begin
            d3 = ($urandom_range(0, 2) == 0) ? 4'hA : 4'($urandom_range(0, 15));
            d2 = 4'($urandom_range(0, 15));
            d1 = 4'($urandom_range(0, 15));
            d0 = 4'($urandom_range(0, 15));
            make_line(d3, d2, d1, d0);
            next_start = after(next_start);
            check_frame(next_start, "random", -1, 4'd0);
        end
    endtask

    task automatic test_reset_midframe();
        int hit;
        d3 = 4'd0; d2 = 4'd6; d1 = 4'd2; d0 = 4'd1;
        make_line(d3, d2, d1, d0);
        next_start = after(next_start);
        hit = next_start + 3 * CHAR_CYC + 4 * DIV + 2;
        while (cyc < hit) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid pre: busy=%b, required 1", busy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (tx_out !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid async: tx=%b busy=%b, required tx=1 busy=0", tx_out, busy);
        end
        repeat (2) @(negedge clk);
        release_reset();
        next_start = PERIOD;
        check_frame(next_start, "after_reset", -1, 4'd0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_minus();
        test_qmark();
        test_midframe();
        test_random();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
